// File: rtl/mem_exc_check_pkg.sv
// Shared definitions for the M-stage memory exception checker: exception codes,
// access-size encodings, region attribute bit positions and the reset region table.
package mem_exc_check_pkg;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    typedef enum logic [1:0] {
        SIZE_BYTE     = 2'b00,
        SIZE_HALF     = 2'b01,
        SIZE_WORD     = 2'b10,
        SIZE_WORD_ALT = 2'b11
    } acc_size_e;

    localparam int ATTR_EN     = 0;
    localparam int ATTR_RD     = 1;
    localparam int ATTR_WR     = 2;
    localparam int ATTR_SUB    = 3;
    localparam int ATTR_RO_EN  = 4;
    localparam int ATTR_RO_LSB = 5;
    localparam int ATTR_RO_MSB = 7;

    // Regions beyond index 2 come out of reset disabled with a zero window.
    function automatic logic [31:0] rst_base(input int idx);
        case (idx)
            1:       return 32'h0000_7F00;
            2:       return 32'h0000_7F10;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] rst_limit(input int idx);
        case (idx)
            0:       return 32'h0000_2FFF;
            1:       return 32'h0000_7F0B;
            2:       return 32'h0000_7F1B;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [7:0] rst_attr(input int idx);
        case (idx)
            0:       return 8'h0F;
            1, 2:    return 8'h57;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/mem_exc_check_if.sv
// M-stage access request and registered check result between pipeline and checker.
interface mem_exc_check_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              stall;
    logic              flush;
    logic [4:0]        exc_in;
    logic              load;
    logic              store;
    logic [1:0]        acc_size;
    logic [ADDR_W-1:0] addr;
    logic              ovf;

    logic              out_valid;
    logic [4:0]        exc_out;
    logic [ADDR_W-1:0] bad_addr;

    modport master (
        output in_valid, stall, flush, exc_in, load, store, acc_size, addr, ovf,
        input  out_valid, exc_out, bad_addr
    );

    modport slave (
        input  in_valid, stall, flush, exc_in, load, store, acc_size, addr, ovf,
        output out_valid, exc_out, bad_addr
    );
endinterface

// File: rtl/mem_region_match.sv
// Region table lookup: finds the lowest-index enabled region whose inclusive
// [base, limit] window contains the address.
module mem_region_match
    import mem_exc_check_pkg::*;
#(
    parameter  int NUM_REG = 4,
    parameter  int ADDR_W  = 32,
    localparam int IDX_W   = $clog2(NUM_REG)
) (
    input  logic [ADDR_W-1:0]              addr,
    input  logic [NUM_REG-1:0][ADDR_W-1:0] base,
    input  logic [NUM_REG-1:0][ADDR_W-1:0] limit,
    input  logic [NUM_REG-1:0][7:0]        attr,
    output logic                           hit,
    output logic [IDX_W-1:0]               hit_idx,
    output logic [7:0]                     hit_attr
);

    // Scan from the top down so the lowest matching index is written last and wins.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_attr = '0;
        for (int i = NUM_REG - 1; i >= 0; i--) begin
            if (attr[i][ATTR_EN] && (addr >= base[i]) && (addr <= limit[i])) begin
                hit      = 1'b1;
                hit_idx  = IDX_W'(i);
                hit_attr = attr[i];
            end
        end
    end

endmodule

// File: rtl/mem_exc_check.sv
// M-stage address exception checker: alignment, overflow, region permissions and
// read-only word protection, with a registered result, sticky first-fault log and fault counter.
module mem_exc_check
    import mem_exc_check_pkg::*;
#(
    parameter  int NUM_REG = 4,
    parameter  int ADDR_W  = 32,
    parameter  int CNT_W   = 16,
    localparam int IDX_W   = $clog2(NUM_REG)
) (
    input  logic               clk,
    input  logic               reset,
    mem_exc_check_if.slave     bus,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [ADDR_W-1:0]  cfg_base,
    input  logic [ADDR_W-1:0]  cfg_limit,
    input  logic [7:0]         cfg_attr,
    input  logic               log_clr,
    output logic               log_valid,
    output logic [4:0]         log_code,
    output logic [ADDR_W-1:0]  log_addr,
    output logic [CNT_W-1:0]   fault_cnt
);

    logic [NUM_REG-1:0][ADDR_W-1:0] base_q, base_d;
    logic [NUM_REG-1:0][ADDR_W-1:0] limit_q, limit_d;
    logic [NUM_REG-1:0][7:0]        attr_q, attr_d;

    logic              out_valid_q, out_valid_d;
    logic [4:0]        exc_out_q, exc_out_d;
    logic [ADDR_W-1:0] bad_addr_q, bad_addr_d;
    logic              log_valid_q, log_valid_d;
    logic [4:0]        log_code_q, log_code_d;
    logic [ADDR_W-1:0] log_addr_q, log_addr_d;
    logic [CNT_W-1:0]  fault_cnt_q, fault_cnt_d;

    logic              hit;
    logic [IDX_W-1:0]  hit_idx;
    logic [7:0]        hit_attr;
    logic [ADDR_W-1:0] ro_addr;
    logic              is_store;
    logic              is_mem;
    logic              sub_word;
    logic              misaligned;
    logic              perm_bad;
    logic              gen_fault;
    logic              fire;
    logic [4:0]        fault_code;
    logic [4:0]        result_code;

    mem_region_match #(
        .NUM_REG (NUM_REG),
        .ADDR_W  (ADDR_W)
    ) u_match (
        .addr     (bus.addr),
        .base     (base_q),
        .limit    (limit_q),
        .attr     (attr_q),
        .hit      (hit),
        .hit_idx  (hit_idx),
        .hit_attr (hit_attr)
    );

    // Table writes land next cycle, so the access checked alongside a write sees the old table.
    always_comb begin
        base_d  = base_q;
        limit_d = limit_q;
        attr_d  = attr_q;
        if (cfg_we && (int'(cfg_idx) < NUM_REG)) begin
            base_d[cfg_idx]  = cfg_base;
            limit_d[cfg_idx] = cfg_limit;
            attr_d[cfg_idx]  = cfg_attr;
        end
    end

    // Every generated fault carries the same code for a given access type, so the
    // individual conditions only need OR-ing; a load+store access counts as a store.
    always_comb begin
        is_store   = bus.store;
        is_mem     = bus.load | bus.store;
        fault_code = is_store ? EXC_ADES : EXC_ADEL;
        sub_word   = (bus.acc_size == SIZE_BYTE) || (bus.acc_size == SIZE_HALF);
        case (bus.acc_size)
            SIZE_BYTE: misaligned = 1'b0;
            SIZE_HALF: misaligned = bus.addr[0];
            default:   misaligned = |bus.addr[1:0];
        endcase
        perm_bad  = is_store ? ~hit_attr[ATTR_WR] : ~hit_attr[ATTR_RD];
        ro_addr   = base_q[hit_idx] + ADDR_W'({hit_attr[ATTR_RO_MSB:ATTR_RO_LSB], 2'b00});
        gen_fault = (bus.exc_in == EXC_NONE) && is_mem &&
                    (misaligned || bus.ovf || !(hit && hit_attr[ATTR_EN]) || perm_bad ||
                     (sub_word && !hit_attr[ATTR_SUB]) ||
                     (is_store && hit_attr[ATTR_RO_EN] && (bus.addr == ro_addr)));
        result_code = gen_fault ? fault_code : bus.exc_in;
        fire        = bus.in_valid && gen_fault && !bus.stall && !bus.flush;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        exc_out_d   = exc_out_q;
        bad_addr_d  = bad_addr_q;
        log_valid_d = log_valid_q;
        log_code_d  = log_code_q;
        log_addr_d  = log_addr_q;
        fault_cnt_d = fault_cnt_q;

        if (bus.flush) begin
            out_valid_d = 1'b0;
            exc_out_d   = '0;
            bad_addr_d  = '0;
        end else if (!bus.stall) begin
            out_valid_d = bus.in_valid;
            exc_out_d   = bus.in_valid ? result_code : '0;
            bad_addr_d  = (bus.in_valid && gen_fault) ? bus.addr : '0;
        end

        if (fire && (fault_cnt_q != '1)) begin
            fault_cnt_d = fault_cnt_q + CNT_W'(1);
        end

        if (log_clr && !bus.stall) begin
            log_valid_d = 1'b0;
            log_code_d  = '0;
            log_addr_d  = '0;
        end
        if (fire && !log_valid_d) begin
            log_valid_d = 1'b1;
            log_code_d  = fault_code;
            log_addr_d  = bus.addr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REG; i++) begin
                base_q[i]  <= ADDR_W'(rst_base(i));
                limit_q[i] <= ADDR_W'(rst_limit(i));
                attr_q[i]  <= rst_attr(i);
            end
            out_valid_q <= 1'b0;
            exc_out_q   <= '0;
            bad_addr_q  <= '0;
            log_valid_q <= 1'b0;
            log_code_q  <= '0;
            log_addr_q  <= '0;
            fault_cnt_q <= '0;
        end else begin
            base_q      <= base_d;
            limit_q     <= limit_d;
            attr_q      <= attr_d;
            out_valid_q <= out_valid_d;
            exc_out_q   <= exc_out_d;
            bad_addr_q  <= bad_addr_d;
            log_valid_q <= log_valid_d;
            log_code_q  <= log_code_d;
            log_addr_q  <= log_addr_d;
            fault_cnt_q <= fault_cnt_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.exc_out   = exc_out_q;
    assign bus.bad_addr  = bad_addr_q;
    assign log_valid     = log_valid_q;
    assign log_code      = log_code_q;
    assign log_addr      = log_addr_q;
    assign fault_cnt     = fault_cnt_q;

endmodule

// File: tb/tb_mem_exc_check.sv
// Directed bench for mem_exc_check: a vector table against the reset region table,
// plus hand sequences for log, stall/flush, config timing, reset and counter saturation.
module tb_mem_exc_check;

    typedef struct {
        logic        ld;
        logic        st;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [4:0]  exc_in;
        logic        ovf;
        logic [4:0]  exp_exc;
        logic        exp_fault;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic [31:0] cfg_base;
    logic [31:0] cfg_limit;
    logic [7:0]  cfg_attr;
    logic        log_clr;
    logic        log_valid, s_log_valid;
    logic [4:0]  log_code, s_log_code;
    logic [31:0] log_addr, s_log_addr;
    logic [15:0] fault_cnt;
    logic [1:0]  s_fault_cnt;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    logic        exp_log_valid = 1'b0;
    logic [4:0]  exp_log_code = '0;
    logic [31:0] exp_log_addr = '0;

    vec_t vecs[22];

    mem_exc_check_if #(.ADDR_W(32)) bus ();
    mem_exc_check_if #(.ADDR_W(32)) bus_s ();

    assign bus_s.in_valid = bus.in_valid;
    assign bus_s.stall    = bus.stall;
    assign bus_s.flush    = bus.flush;
    assign bus_s.exc_in   = bus.exc_in;
    assign bus_s.load     = bus.load;
    assign bus_s.store    = bus.store;
    assign bus_s.acc_size = bus.acc_size;
    assign bus_s.addr     = bus.addr;
    assign bus_s.ovf      = bus.ovf;

    mem_exc_check #(.NUM_REG(4), .ADDR_W(32), .CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_base  (cfg_base),
        .cfg_limit (cfg_limit),
        .cfg_attr  (cfg_attr),
        .log_clr   (log_clr),
        .log_valid (log_valid),
        .log_code  (log_code),
        .log_addr  (log_addr),
        .fault_cnt (fault_cnt)
    );

    mem_exc_check #(.NUM_REG(4), .ADDR_W(32), .CNT_W(2)) dut_small (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_s),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_base  (cfg_base),
        .cfg_limit (cfg_limit),
        .cfg_attr  (cfg_attr),
        .log_clr   (log_clr),
        .log_valid (s_log_valid),
        .log_code  (s_log_code),
        .log_addr  (s_log_addr),
        .fault_cnt (s_fault_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic ld, input logic st, input logic [1:0] sz,
                                input logic [31:0] a, input logic [4:0] ei, input logic ov,
                                input logic [4:0] ee, input logic ef);
        vec_t v;
        v.ld = ld; v.st = st; v.sz = sz; v.addr = a; v.exc_in = ei; v.ovf = ov;
        v.exp_exc = ee; v.exp_fault = ef;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic model_fault(input logic [4:0] code, input logic [31:0] a);
        exp_cnt++;
        if (!exp_log_valid) begin
            exp_log_valid = 1'b1;
            exp_log_code  = code;
            exp_log_addr  = a;
        end
    endtask

    task automatic apply_stimulus(input logic ld, input logic st, input logic [1:0] sz,
                                  input logic [31:0] a, input logic [4:0] ei, input logic ov);
        bus.in_valid = 1'b1;
        bus.load     = ld;
        bus.store    = st;
        bus.acc_size = sz;
        bus.addr     = a;
        bus.exc_in   = ei;
        bus.ovf      = ov;
    endtask

    task automatic check_output(input string tag, input logic exp_valid,
                                input logic [4:0] exp_exc, input logic [31:0] exp_bad);
        int sat;
        sat = (exp_cnt > 3) ? 3 : exp_cnt;
        check({tag, " out_valid"}, 64'(bus.out_valid), 64'(exp_valid));
        check({tag, " exc_out"},   64'(bus.exc_out),   64'(exp_exc));
        check({tag, " bad_addr"},  64'(bus.bad_addr),  64'(exp_bad));
        check({tag, " fault_cnt"}, 64'(fault_cnt),     64'(exp_cnt));
        check({tag, " small_cnt"}, 64'(s_fault_cnt),   64'(sat));
        check({tag, " log_valid"}, 64'(log_valid),     64'(exp_log_valid));
        check({tag, " log_code"},  64'(log_code),      64'(exp_log_code));
        check({tag, " log_addr"},  64'(log_addr),      64'(exp_log_addr));
        check({tag, " small_log"}, 64'(s_log_valid),   64'(exp_log_valid));
    endtask

    task automatic run_access(input string tag, input logic ld, input logic st,
                              input logic [1:0] sz, input logic [31:0] a, input logic [4:0] ei,
                              input logic ov, input logic [4:0] ee, input logic ef);
        apply_stimulus(ld, st, sz, a, ei, ov);
        @(negedge clk);
        if (ef) model_fault(ee, a);
        check_output(tag, 1'b1, ee, ef ? a : 32'h0);
    endtask

    task automatic model_reset();
        exp_cnt       = 0;
        exp_log_valid = 1'b0;
        exp_log_code  = '0;
        exp_log_addr  = '0;
    endtask

    initial begin
        reset = 1'b0;
        cfg_we = 1'b0; cfg_idx = '0; cfg_base = '0; cfg_limit = '0; cfg_attr = '0;
        log_clr = 1'b0;
        bus.in_valid = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0; bus.exc_in = '0;
        bus.load = 1'b0; bus.store = 1'b0; bus.acc_size = 2'b10; bus.addr = '0; bus.ovf = 1'b0;

        //                ld    st    sz     addr           exc   ovf   exp   fault
        vecs[0]  = mk(1'b1, 1'b0, 2'b10, 32'h0000_1000, 5'd0, 1'b0, 5'd0,  1'b0);
        vecs[1]  = mk(1'b0, 1'b1, 2'b01, 32'h0000_0003, 5'd0, 1'b0, 5'd5,  1'b1);
        vecs[2]  = mk(1'b0, 1'b1, 2'b10, 32'h0000_7F08, 5'd0, 1'b0, 5'd5,  1'b1);
        vecs[3]  = mk(1'b1, 1'b0, 2'b10, 32'h0000_7F08, 5'd0, 1'b0, 5'd0,  1'b0);
        vecs[4]  = mk(1'b1, 1'b0, 2'b00, 32'h0000_7F04, 5'd0, 1'b0, 5'd4,  1'b1);
        vecs[5]  = mk(1'b1, 1'b0, 2'b10, 32'h0000_5000, 5'd10, 1'b0, 5'd10, 1'b0);
        vecs[6]  = mk(1'b1, 1'b0, 2'b10, 32'h0000_5000, 5'd0, 1'b0, 5'd4,  1'b1);
        vecs[7]  = mk(1'b1, 1'b0, 2'b10, 32'h0000_1000, 5'd0, 1'b1, 5'd4,  1'b1);
        vecs[8]  = mk(1'b1, 1'b0, 2'b10, 32'h0000_1002, 5'd0, 1'b0, 5'd4,  1'b1);
        vecs[9]  = mk(1'b1, 1'b0, 2'b11, 32'h0000_1001, 5'd0, 1'b0, 5'd4,  1'b1);
        vecs[10] = mk(1'b1, 1'b0, 2'b01, 32'h0000_1002, 5'd0, 1'b0, 5'd0,  1'b0);
        vecs[11] = mk(1'b0, 1'b0, 2'b10, 32'h0000_5001, 5'd0, 1'b0, 5'd0,  1'b0);
        vecs[12] = mk(1'b0, 1'b0, 2'b10, 32'h0000_5001, 5'd7, 1'b0, 5'd7,  1'b0);
        vecs[13] = mk(1'b1, 1'b1, 2'b10, 32'h0000_7F18, 5'd0, 1'b0, 5'd5,  1'b1);
        vecs[14] = mk(1'b0, 1'b1, 2'b10, 32'h0000_7F14, 5'd0, 1'b0, 5'd0,  1'b0);
        vecs[15] = mk(1'b1, 1'b0, 2'b10, 32'h0000_2FFC, 5'd0, 1'b0, 5'd0,  1'b0);
        vecs[16] = mk(1'b1, 1'b0, 2'b01, 32'h0000_3000, 5'd0, 1'b0, 5'd4,  1'b1);
        vecs[17] = mk(1'b0, 1'b1, 2'b00, 32'h0000_2FFF, 5'd0, 1'b0, 5'd0,  1'b0);
        vecs[18] = mk(1'b0, 1'b1, 2'b10, 32'h0000_7F0C, 5'd0, 1'b0, 5'd5,  1'b1);
        vecs[19] = mk(1'b1, 1'b0, 2'b10, 32'h0000_1001, 5'd3, 1'b1, 5'd3,  1'b0);
        vecs[20] = mk(1'b1, 1'b0, 2'b10, 32'h0000_0000, 5'd0, 1'b0, 5'd0,  1'b0);
        vecs[21] = mk(1'b0, 1'b1, 2'b01, 32'h0000_7F02, 5'd0, 1'b0, 5'd5,  1'b1);

        repeat (3) @(negedge clk);
        check_output("reset", 1'b0, 5'd0, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 22; i++) begin
            run_access($sformatf("vec%0d", i), vecs[i].ld, vecs[i].st, vecs[i].sz,
                       vecs[i].addr, vecs[i].exc_in, vecs[i].ovf, vecs[i].exp_exc,
                       vecs[i].exp_fault);
        end

        // log_clr together with a new fault: clear then capture
        log_clr = 1'b1;
        apply_stimulus(1'b1, 1'b0, 2'b10, 32'h0000_5004, 5'd0, 1'b0);
        @(negedge clk);
        model_reset_log();
        model_fault(5'd4, 32'h0000_5004);
        check_output("clr_fault", 1'b1, 5'd4, 32'h0000_5004);

        bus.in_valid = 1'b0;
        @(negedge clk);
        model_reset_log();
        check_output("clr_idle", 1'b0, 5'd0, 32'h0);
        log_clr = 1'b0;

        run_access("log_first", 1'b0, 1'b1, 2'b10, 32'h0000_7F08, 5'd0, 1'b0, 5'd5, 1'b1);
        run_access("log_hold",  1'b1, 1'b0, 2'b10, 32'h0000_5000, 5'd0, 1'b0, 5'd4, 1'b1);

        run_access("pre_stall", 1'b1, 1'b0, 2'b10, 32'h0000_1000, 5'd0, 1'b0, 5'd0, 1'b0);
        bus.stall = 1'b1;
        apply_stimulus(1'b0, 1'b1, 2'b01, 32'h0000_0003, 5'd0, 1'b0);
        @(negedge clk);
        check_output("stall", 1'b1, 5'd0, 32'h0);
        bus.flush = 1'b1;
        @(negedge clk);
        check_output("stall_flush", 1'b0, 5'd0, 32'h0);
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_output("idle", 1'b0, 5'd0, 32'h0);

        // region3 write: same-cycle access still sees the disabled entry
        cfg_we = 1'b1; cfg_idx = 2'd3;
        cfg_base = 32'h0000_6000; cfg_limit = 32'h0000_60FF; cfg_attr = 8'h03;
        run_access("cfg_same", 1'b0, 1'b1, 2'b10, 32'h0000_6000, 5'd0, 1'b0, 5'd5, 1'b1);
        cfg_we = 1'b0;
        run_access("cfg_store", 1'b0, 1'b1, 2'b10, 32'h0000_6000, 5'd0, 1'b0, 5'd5, 1'b1);
        run_access("cfg_load",  1'b1, 1'b0, 2'b10, 32'h0000_6000, 5'd0, 1'b0, 5'd0, 1'b0);
        run_access("cfg_byte",  1'b1, 1'b0, 2'b00, 32'h0000_6001, 5'd0, 1'b0, 5'd4, 1'b1);
        run_access("cfg_limit", 1'b1, 1'b0, 2'b10, 32'h0000_60FC, 5'd0, 1'b0, 5'd0, 1'b0);
        run_access("cfg_past",  1'b1, 1'b0, 2'b10, 32'h0000_6100, 5'd0, 1'b0, 5'd4, 1'b1);

        // reset during a stalled config write restores the reset table
        reset = 1'b0; bus.stall = 1'b1;
        cfg_we = 1'b1; cfg_idx = 2'd3; cfg_attr = 8'h07;
        @(negedge clk);
        model_reset();
        check_output("mid_reset", 1'b0, 5'd0, 32'h0);
        reset = 1'b1; bus.stall = 1'b0; cfg_we = 1'b0;

        run_access("sat1", 1'b1, 1'b0, 2'b10, 32'h0000_6000, 5'd0, 1'b0, 5'd4, 1'b1);
        run_access("sat2", 1'b0, 1'b1, 2'b01, 32'h0000_0003, 5'd0, 1'b0, 5'd5, 1'b1);
        run_access("sat3", 1'b0, 1'b1, 2'b01, 32'h0000_0003, 5'd0, 1'b0, 5'd5, 1'b1);
        run_access("sat4", 1'b0, 1'b1, 2'b01, 32'h0000_0003, 5'd0, 1'b0, 5'd5, 1'b1);
        check("sat small_cnt_value", 64'(s_fault_cnt), 64'd3);

        bus.flush = 1'b1;
        apply_stimulus(1'b0, 1'b1, 2'b01, 32'h0000_0003, 5'd0, 1'b0);
        @(negedge clk);
        check_output("flush", 1'b0, 5'd0, 32'h0);
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic model_reset_log();
        exp_log_valid = 1'b0;
        exp_log_code  = '0;
        exp_log_addr  = '0;
    endtask

endmodule
